// File: rtl/uart_baud_gen_if.sv
// Control and strobe bundle between the baud generator and the UART TX/RX engines.
// The master drives enable, phase sync and divisor writes; the slave returns the ticks.
`timescale 1ns/1ps
interface uart_baud_gen_if #(
    parameter int DIV_W = 16
);
    logic             en;
    logic             sync;
    logic             div_wr;
    logic [DIV_W-1:0] div_in;
    logic [DIV_W-1:0] div_out;
    logic             tick_16x;
    logic             tick_mid;
    logic             tick_1x;

    modport master (
        output en, sync, div_wr, div_in,
        input  div_out, tick_16x, tick_mid, tick_1x
    );

    modport slave (
        input  en, sync, div_wr, div_in,
        output div_out, tick_16x, tick_mid, tick_1x
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Baud tick generator: 16x oversample, mid-bit and bit-end strobes from a programmable
// divisor, with glitch-free divisor switching at period boundaries and phase resync.
`timescale 1ns/1ps
module uart_baud_gen #(
    parameter int CLK_FREQ     = 11059200,
    parameter int DEFAULT_BAUD = 115200,
    parameter int DIV_W        = 16,
    parameter int DEFAULT_DIV  = CLK_FREQ / (16 * DEFAULT_BAUD)
) (
    input  logic            clk,
    input  logic            rst,
    uart_baud_gen_if.slave  bus
);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] div_act_reg,  div_act_next;
    logic [DIV_W-1:0] div_pend_reg, div_pend_next;
    logic             pend_v_reg,   pend_v_next;
    logic [DIV_W-1:0] cnt_reg,      cnt_next;
    logic [3:0]       os_reg,       os_next;
    logic             tick_16x_reg, tick_16x_next;
    logic             tick_mid_reg, tick_mid_next;
    logic             tick_1x_reg,  tick_1x_next;

    logic [DIV_W-1:0] div_new;
    logic [DIV_W-1:0] reload;
    logic             apply;

    // A write on an applying edge bypasses the pending register so it takes effect at once.
    assign div_new = bus.div_wr ? bus.div_in : (pend_v_reg ? div_pend_reg : div_act_reg);
    assign apply   = !bus.en || bus.sync || (cnt_reg == '0);
    // Divisor 0 behaves as 1; every reload is an applying edge, so it uses div_new.
    assign reload  = (div_new == '0) ? '0 : div_new - DIV_W'(1);

    always_comb begin
        div_act_next  = div_act_reg;
        div_pend_next = div_pend_reg;
        pend_v_next   = pend_v_reg;
        cnt_next      = cnt_reg;
        os_next       = os_reg;
        tick_16x_next = 1'b0;
        tick_mid_next = 1'b0;
        tick_1x_next  = 1'b0;

        if (bus.div_wr) begin
            div_pend_next = bus.div_in;
            pend_v_next   = 1'b1;
        end
        if (apply) begin
            div_act_next = div_new;
            pend_v_next  = 1'b0;
        end

        if (!bus.en || bus.sync) begin
            cnt_next = reload;
            os_next  = 4'd0;
        end else if (cnt_reg == '0) begin
            cnt_next      = reload;
            os_next       = os_reg + 4'd1;
            tick_16x_next = 1'b1;
            tick_mid_next = (os_reg == 4'd7);
            tick_1x_next  = (os_reg == 4'd15);
        end else begin
            cnt_next = cnt_reg - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_act_reg  <= DEF_DIV;
            div_pend_reg <= DEF_DIV;
            pend_v_reg   <= 1'b0;
            cnt_reg      <= DEF_DIV - DIV_W'(1);
            os_reg       <= 4'd0;
            tick_16x_reg <= 1'b0;
            tick_mid_reg <= 1'b0;
            tick_1x_reg  <= 1'b0;
        end else begin
            div_act_reg  <= div_act_next;
            div_pend_reg <= div_pend_next;
            pend_v_reg   <= pend_v_next;
            cnt_reg      <= cnt_next;
            os_reg       <= os_next;
            tick_16x_reg <= tick_16x_next;
            tick_mid_reg <= tick_mid_next;
            tick_1x_reg  <= tick_1x_next;
        end
    end

    assign bus.div_out  = div_act_reg;
    assign bus.tick_16x = tick_16x_reg;
    assign bus.tick_mid = tick_mid_reg;
    assign bus.tick_1x  = tick_1x_reg;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: latencies, periods, divisor switching, sync and resets.
`timescale 1ns/1ps
module tb_uart_baud_gen;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   total;

    uart_baud_gen_if #(.DIV_W(16)) bus ();

    uart_baud_gen #(.DIV_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
        $display("check %-16s observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.tick_16x;
            1:       return bus.tick_mid;
            default: return bus.tick_1x;
        endcase
    endfunction

    // Edges until the selected strobe is seen high; -1 if the bound expires.
    task automatic edges_until(input int sel, input int max, output int cnt);
        cnt = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (sig(sel) === 1'b1) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        bus.en     = 1'b0;
        bus.sync   = 1'b0;
        bus.div_wr = 1'b0;
        bus.div_in = '0;
        repeat (3) step();
        chk("rst_div_out", 32'(bus.div_out), 6);
        chk("rst_tick_16x", 32'(bus.tick_16x), 0);
        chk("rst_tick_mid", 32'(bus.tick_mid), 0);
        chk("rst_tick_1x", 32'(bus.tick_1x), 0);

        // Default divisor 6 out of reset
        rst    = 1'b1;
        bus.en = 1'b1;
        edges_until(0, 200, n); total = n;
        chk("first_16x", n, 6);
        edges_until(1, 200, n); total += n;
        chk("first_mid", total, 48);
        edges_until(2, 200, n); total += n;
        chk("first_1x", total, 96);
        edges_until(2, 200, n);
        chk("period_1x_115k", n, 96);
        chk("div_out_6", 32'(bus.div_out), 6);

        // Mid-period write of 72 waits for the reload
        step(); step();
        bus.div_wr = 1'b1; bus.div_in = 16'd72;
        step();
        bus.div_wr = 1'b0;
        chk("wr_pending", 32'(bus.div_out), 6);
        step(); step();
        chk("pre_reload_div", 32'(bus.div_out), 6);
        chk("pre_reload_tick", 32'(bus.tick_16x), 0);
        step();
        chk("reload_tick", 32'(bus.tick_16x), 1);
        chk("reload_div", 32'(bus.div_out), 72);
        edges_until(0, 200, n);
        chk("period_16x_72", n, 72);
        edges_until(2, 2000, n);
        edges_until(2, 2000, n);
        chk("period_1x_9600", n, 1152);

        // Sync at an arbitrary point
        repeat (10) step();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        chk("sync_no_tick", 32'(bus.tick_16x), 0);
        edges_until(0, 200, n); total = n;
        chk("sync_first_16x", n, 72);
        edges_until(1, 1000, n); total += n;
        chk("sync_mid", total, 576);
        edges_until(2, 1000, n); total += n;
        chk("sync_1x", total, 1152);

        // Divisor 0 with bypass on a sync edge
        bus.div_wr = 1'b1; bus.div_in = 16'd0; bus.sync = 1'b1;
        step();
        bus.div_wr = 1'b0; bus.sync = 1'b0;
        chk("div0_out", 32'(bus.div_out), 0);
        chk("div0_sync_tick", 32'(bus.tick_16x), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("div0_every_cycle", 32'(bus.tick_16x), 1);
        end
        edges_until(2, 100, n);
        chk("div0_first_1x", n + 3, 16);
        edges_until(2, 100, n);
        chk("div0_period_1x", n, 16);

        // Divisor 1 behaves identically
        bus.div_wr = 1'b1; bus.div_in = 16'd1; bus.sync = 1'b1;
        step();
        bus.div_wr = 1'b0; bus.sync = 1'b0;
        chk("div1_out", 32'(bus.div_out), 1);
        edges_until(0, 100, n);
        chk("div1_first_16x", n, 1);
        edges_until(2, 100, n);
        chk("div1_first_1x", n + 1, 16);
        edges_until(2, 100, n);
        chk("div1_period_1x", n, 16);

        // Two writes before a reload: last one wins
        bus.div_wr = 1'b1; bus.div_in = 16'd6; bus.sync = 1'b1;
        step();
        bus.sync = 1'b0; bus.div_in = 16'd10;
        step();
        bus.div_in = 16'd20;
        step();
        bus.div_wr = 1'b0;
        chk("double_wr_hold", 32'(bus.div_out), 6);
        edges_until(0, 100, n);
        chk("double_wr_reload", n, 4);
        chk("double_wr_div", 32'(bus.div_out), 20);
        edges_until(0, 100, n);
        chk("period_16x_20", n, 20);

        // Sync landing on the reload edge swallows that tick
        repeat (19) step();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        chk("sync_on_reload", 32'(bus.tick_16x), 0);
        edges_until(0, 100, n);
        chk("sync_reload_next", n, 20);

        // Enable dropped for 3 cycles mid-bit
        repeat (50) step();
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en_off_ticks", 32'({bus.tick_16x, bus.tick_mid, bus.tick_1x}), 0);
        end
        bus.en = 1'b1;
        edges_until(0, 100, n); total = n;
        chk("reenable_16x", n, 20);
        edges_until(1, 500, n); total += n;
        chk("reenable_mid", total, 160);

        // Asynchronous reset while a tick is high
        edges_until(0, 100, n);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_tick", 32'(bus.tick_16x), 0);
        chk("async_rst_div", 32'(bus.div_out), 6);
        #3 rst = 1'b1;
        edges_until(0, 100, n);
        chk("post_rst_16x", n, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Baud-rate tick generator clocked from the 11.0592 MHz board oscillator domain.
- Produces 16x oversample, mid-bit and bit-rate strobes for the UART TX/RX engines.
- Provides a programmable divisor, glitch-free divisor update and phase re-synchronisation, so RX can align sampling to a start-bit edge.

Parameters:
- CLK_FREQ, 11059200: input clock frequency in Hz; documentation only, used for the default divisor.
- DEFAULT_BAUD, 115200: baud rate selected out of reset.
- DIV_W, 16: divisor width.
- DEFAULT_DIV, CLK_FREQ/(16*DEFAULT_BAUD) = 6: divisor loaded at reset.

Ports:
- clk  in  1  11.0592 MHz clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  generator enable.
- sync  in  1  one-cycle phase restart, pulsed by RX on the start-bit falling edge.
- div_wr  in  1  divisor write strobe.
- div_in  in  DIV_W  new divisor.
- div_out  out  DIV_W  currently active divisor.
- tick_16x  out  1  one-cycle oversample strobe.
- tick_mid  out  1  one-cycle strobe at the bit centre (oversample phase 7).
- tick_1x  out  1  one-cycle strobe at the bit end (oversample phase 15).

Behaviour:
- Reset (rst=0, asynchronous):
  - div_act=DEFAULT_DIV, div_pend=DEFAULT_DIV, pend_v=0.
  - cnt=DEFAULT_DIV-1, os=0.
  - tick_16x, tick_mid and tick_1x all 0; div_out=DEFAULT_DIV.
- Reset mid-operation aborts the current bit immediately. No tick is emitted on the release edge.
- Effective divisor: a divisor value of 0 is treated as 1, i.e. tick_16x every cycle. Reload value R = max(div,1)-1.
- div_wr: captures div_in into div_pend and sets pend_v.
  - A later div_wr before application overwrites div_pend (last write wins).
- Divisor application: div_act<=div_pend and pend_v<=0 on any edge where one of the following holds:
  - en=0;
  - sync=1;
  - cnt==0 with en=1 (reload point).
  - The reload at that edge uses the new value. The divisor therefore never changes mid-period.
- div_wr and an application condition on the same edge: div_in is used directly (bypass).
- en=0: cnt<=R(active), os<=0, all ticks 0 on the next edge.
- en=1, sync=0, at each edge:
  - cnt==0: cnt<=R, tick_16x<=1, os<=os+1 (4-bit wrap 15->0).
    - tick_mid<=(os==7).
    - tick_1x<=(os==15).
  - otherwise: cnt<=cnt-1 and all ticks<=0.
- sync=1 (highest priority when en=1): cnt<=R, os<=0, all ticks 0.
  - A sync coinciding with cnt==0 suppresses that tick.
- Latency from the en-rising sample edge or from a sync edge:
  - first tick_16x is high after exactly D edges (D = effective divisor);
  - tick_mid after 8*D edges;
  - tick_1x after 16*D edges.
- Steady-state periods: tick_16x every D cycles; tick_mid and tick_1x every 16*D cycles, offset by 8*D.
- All ticks are registered single-cycle pulses and never stretch. tick_mid and tick_1x only ever assert together with tick_16x.
- Arithmetic: cnt is DIV_W bits and os is 4 bits, both unsigned. No overflow is possible.

Test Plan:
- Reset defaults: release rst, en=1, default divisor 6 -> first tick_16x on edge 6, tick_mid on edge 48, tick_1x on edge 96; tick_1x period stays 96 cycles (115200 baud); div_out=6 throughout.
- Divisor write: div_wr with div_in=72 in mid-period at divisor 6 -> current 6-cycle period completes unchanged. After that, tick_16x period is 72 and tick_1x period is 1152 (9600 baud). div_out changes exactly at the reload edge.
- Sync alignment: after running, pulse sync at an arbitrary cycle -> no tick on the sync edge; tick_mid 8*D edges later; tick_1x 16*D edges later. Sync issued on the same edge as cnt==0 suppresses that tick.
- Divisor edge cases:
  - div_in=0 -> tick_16x high every cycle and tick_1x every 16 cycles.
  - div_in=1 -> identical behaviour.
  - Two div_wr (10 then 20) before a reload -> 20 applied.
- Enable / reset abort:
  - Drop en for 3 cycles mid-bit -> ticks cease and os clears. Re-enable -> first tick_16x after D edges.
  - Assert rst asynchronously between edges -> outputs 0 and div_out=6 immediately, without waiting for a clock edge.
